wide_word_loader: RTL



---
 rtl/wide_word_loader.sv | 67 ++++++
 1 files changed

// File: rtl/wide_word_loader.sv
// wide_word_loader: commits a WIDTH-bit word atomically from a constant pattern or a stream of BEAT-bit beats
module wide_word_loader #(
  parameter int WIDTH = 1050,
  parameter int BEAT = 64,
  parameter logic [BEAT-1:0] PATTERN = 64'hffff0000ffff0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             in_valid,
  input  logic [BEAT-1:0]  in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid,
  output logic             busy,
  output logic             done
);
  localparam int NBEATS = (WIDTH + BEAT - 1) / BEAT;
  localparam int LOW = (NBEATS - 1) * BEAT;
  localparam int CW = $clog2(NBEATS);
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t r_state, w_next_state;
  logic [CW-1:0] r_cnt;
  logic [LOW-1:0] r_shadow;
  logic w_cmd, w_adv, w_last, w_commit, w_unused;
  logic [WIDTH-1:0] w_next_word;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next_state;
  always_comb begin
    w_next_state = r_state == IDLE ? (w_cmd && cmd_op == 2'b11 ? LOAD : IDLE)
                                   : (abort || w_last ? IDLE : LOAD);
  end
  always_comb begin
    cmd_ready = !rst && r_state == IDLE;
    in_ready = r_state == LOAD;
    busy = r_state == LOAD;
  end
  assign w_cmd = cmd_valid && cmd_ready;
  assign w_adv = in_valid && in_ready && !abort;
  assign w_last = w_adv && r_cnt == LAST;
  assign w_commit = (w_cmd && cmd_op != 2'b11) || w_last;
  // the final beat is merged straight from in_data so every bit lands on the same edge
  assign w_next_word = in_ready ? {in_data[WIDTH-LOW-1:0], r_shadow}
                     : cmd_op == 2'b01 ? {PATTERN, {(WIDTH-BEAT){1'b0}}}
                     : cmd_op == 2'b10 ? {{(WIDTH-BEAT){1'b0}}, PATTERN} : '0;
  assign w_unused = &{1'b0, in_data[BEAT-1:WIDTH-LOW]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      word_o <= '0;
      word_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      r_cnt <= w_adv ? (w_last ? '0 : r_cnt + 1'b1) : abort ? '0 : r_cnt;
      word_o <= w_commit ? w_next_word : word_o;
      word_valid <= word_valid || w_commit;
      done <= w_commit;
    end
  always_ff @(posedge clk)
    for (int k = 0; k < NBEATS - 1; k++)
      if (w_adv && r_cnt == CW'(k)) r_shadow[k*BEAT +: BEAT] <= in_data;
endmodule
